fetch_pc_ctrl: RTL and testbench
================================

# fetch_pc_ctrl

Sequencing controller for the JOF32 fetch stage. It owns the program-counter register and drives the select of the fetch-stage PC multiplexer: sequential (`pc + 1`), branch target or jump target. It also handles pipeline stalls, wrong-path flush after a redirect, and halt. It sits between the decode/execute redirect signals and the instruction-memory address port.

## Interface
Parameters:
- `PC_W`, 10: PC width in bits.
- `RESET_PC`, 0: PC value loaded on reset.
- `FLUSH_CYCLES`, 1: bubble cycles after a redirect. Legal range is 1–7.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `stall`, in, 1: hold the PC. Comes from the hazard unit.
- `branch_taken`, in, 1: taken-branch redirect from EX.
- `jump_req`, in, 1: jump redirect from ID.
- `halt_req`, in, 1: halt instruction decoded.
- `pc_next`, in, PC_W: selected next PC, returned from the fetch mux output.
- `pc`, out, PC_W: current fetch address, registered.
- `pc_seq`, out, PC_W: `pc + 1`, combinational. Feeds the mux sequential input.
- `dir_sl`, out, 3: mux select, combinational. 0 = sequential, 1 = branch, 2 = jump.
- `fetch_valid`, out, 1: the instruction at `pc` is on the correct path. Registered.
- `flush`, out, 1: kill IF/ID contents this cycle.
- `halted`, out, 1: the controller is in HALT.

## Operation
- States: BOOT, RUN, FLUSH, HALT.
- Reset values: state = BOOT, `pc` = RESET_PC, `fetch_valid` = 0, `flush` = 0, `halted` = 0, flush counter = 0, `dir_sl` = 0.
- BOOT: held for 1 cycle with `pc` unchanged, then RUN with `fetch_valid` = 1.
- Event priority, evaluated every cycle in RUN and FLUSH: `branch_taken` > `jump_req` > `halt_req` > `stall` > sequential.
- Branch accepted:
  - `dir_sl` = 1.
  - `pc` ← `pc_next` (the branch target).
  - `flush` = 1 in the same cycle.
  - Next state FLUSH; counter ← FLUSH_CYCLES.
- Jump accepted: same as branch, but `dir_sl` = 2.
- Halt accepted (RUN only): `pc` held, next state HALT, `fetch_valid` ← 0.
- Stall (RUN, no redirect or halt): `pc` held, `dir_sl` = 0, `fetch_valid` unchanged.
- Sequential: `dir_sl` = 0, `pc` ← `pc_next` (equals `pc_seq`). Wraps from 2^PC_W−1 to 0 with no flag.
- FLUSH:
  - `flush` = 1, `fetch_valid` = 0, `pc` held at the target.
  - Counter decrements each cycle. At 1 it transitions to RUN and sets `fetch_valid` ← 1.
  - `stall` during FLUSH is ignored; the count continues.
  - A new redirect during FLUSH is accepted: it loads the new target and reloads the counter.
  - `halt_req` during FLUSH is ignored (the halt is on the wrong path).
- HALT: all inputs except `rst` are ignored. `pc` held, `halted` = 1, `flush` = 0, `dir_sl` = 0.
- Redirect during a stall: the redirect wins. The PC loads the target and the stall is dropped for that cycle.
- `flush` = (redirect accepted this cycle) OR (state == FLUSH).
- `rst` overrides everything in any state, including mid-FLUSH; reset values apply on the next edge.

## Timing
- `dir_sl`, `pc_seq` and redirect-cycle `flush` are combinational from inputs and state. The path into `pc_next` is external and combinational, so no loop exists.
- `pc`, `fetch_valid`, `halted` and state change only on `clk` edges.
- Redirect latency: target appears on `pc` 1 cycle after `branch_taken`/`jump_req`. `fetch_valid` returns 1 + FLUSH_CYCLES cycles after the redirect cycle.
- Sequential throughput: 1 PC per cycle when not stalled.

## Structure
- Shared package `jof32_fetch_pkg`:
  - select codes SEL_SEQ = 3'd0, SEL_BR = 3'd1, SEL_JMP = 3'd2;
  - state encodings;
  - default PC_W.
- The existing fetch PC multiplexer is instantiated alongside this block in the fetch top, not inside it.
- One natural sub-module: `flush_counter`, a 3-bit load/decrement counter with a `done` output.

## Test plan
- Reset then 4 free-running cycles → `pc` = 0, 0 (BOOT), 1, 2, 3; `fetch_valid` rises in cycle 2; `dir_sl` = 0 throughout.
- At `pc` = 5, `branch_taken` with mux branch input 0x2A0 → `dir_sl` = 1 and `flush` = 1 that cycle; `pc` = 0x2A0 next; `fetch_valid` = 0 for 1 cycle, then `pc` advances to 0x2A1.
- `branch_taken` and `jump_req` together, branch 0x010, jump 0x300 → `dir_sl` = 1 and `pc` = 0x010. Then, during FLUSH, `jump_req` to 0x300 → `pc` = 0x300 and the counter reloads.
- `pc` = 0x3FF, no stall → `pc` = 0x000 next. `stall` held 3 cycles at `pc` = 7 → `pc` stays 7 and `fetch_valid` stays 1.
- `halt_req` at `pc` = 9 → `halted` = 1 and `pc` frozen at 9 for 10 cycles despite `branch_taken`. Then `rst` → `pc` = 0, state BOOT.
- `rst` asserted mid-FLUSH with FLUSH_CYCLES = 3 → `flush` = 0, `fetch_valid` = 0 and `pc` = RESET_PC after that edge.

Source files
------------

// File: rtl/jof32_fetch_pkg.sv
// Shared definitions for the JOF32 fetch stage: PC-mux select codes,
// sequencing-controller state encodings and the default PC width.
package jof32_fetch_pkg;

    // Default program-counter width in bits.
    localparam int unsigned PC_W_DEFAULT = 10;

    // Width of the post-redirect bubble counter (FLUSH_CYCLES is 1..7).
    localparam int unsigned FLUSH_CNT_W = 3;

    // Select codes driven onto the fetch PC multiplexer.
    localparam logic [2:0] SEL_SEQ = 3'd0;
    localparam logic [2:0] SEL_BR  = 3'd1;
    localparam logic [2:0] SEL_JMP = 3'd2;

    // Sequencing controller states.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // The single event that wins arbitration in a given cycle.
    typedef enum logic [2:0] {
        EV_SEQ    = 3'd0,
        EV_STALL  = 3'd1,
        EV_HALT   = 3'd2,
        EV_JUMP   = 3'd3,
        EV_BRANCH = 3'd4
    } fetch_event_e;

    // Fixed priority: branch > jump > halt > stall > sequential.
    // The branch is older (EX) than the jump (ID), so it always wins.
    function automatic fetch_event_e resolve_event(
        input logic branch_taken,
        input logic jump_req,
        input logic halt_req,
        input logic stall
    );
        fetch_event_e ev;
        if (branch_taken)  ev = EV_BRANCH;
        else if (jump_req) ev = EV_JUMP;
        else if (halt_req) ev = EV_HALT;
        else if (stall)    ev = EV_STALL;
        else               ev = EV_SEQ;
        return ev;
    endfunction

endpackage

// File: rtl/flush_counter.sv
// Load/decrement counter that times the wrong-path bubble after a redirect.
// done is asserted on the last bubble cycle (count of 1).
module flush_counter
    import jof32_fetch_pkg::*;
#(
    parameter int unsigned W = FLUSH_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count;

    // Count register: load wins over decrement; the count never underflows.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with <= so every flop samples pre-edge values.
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // A count of 0 is also treated as done, so a stray zero can never
    // trap the controller in its flush state.
    assign done = (count <= W'(1));

endmodule

// File: rtl/fetch_pc_ctrl.sv
// JOF32 fetch sequencing controller. Owns the PC register, drives the
// fetch PC-mux select, and sequences boot, stalls, post-redirect flush
// and halt. The mux itself lives beside this block in the fetch top and
// returns its output on pc_next.
module fetch_pc_ctrl
    import jof32_fetch_pkg::*;
#(
    parameter int unsigned     PC_W         = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int unsigned     FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic            jump_req,
    input  logic            halt_req,
    input  logic [PC_W-1:0] pc_next,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_seq,
    output logic [2:0]      dir_sl,
    output logic            fetch_valid,
    output logic            flush,
    output logic            halted
);

    // Bubble count reloaded on every accepted redirect.
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    fetch_event_e    ev;
    logic [PC_W-1:0] pc_d;
    logic            fetch_valid_d;
    logic            redirect;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_done;

    // Sequential address for the mux; wraps silently at the top of memory.
    assign pc_seq = pc + PC_W'(1);

    assign ev = resolve_event(branch_taken, jump_req, halt_req, stall);

    // Next-state, mux select and register next-values from state and requests.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        state_nxt     = state;
        pc_d          = pc;
        fetch_valid_d = fetch_valid;
        dir_sl        = SEL_SEQ;
        redirect      = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;

        unique case (state)
            ST_BOOT: begin
                // One idle cycle out of reset, then start fetching at RESET_PC.
                state_nxt     = ST_RUN;
                fetch_valid_d = 1'b1;
            end

            ST_RUN: begin
                unique case (ev)
                    EV_BRANCH: begin
                        dir_sl   = SEL_BR;
                        redirect = 1'b1;
                    end
                    EV_JUMP: begin
                        dir_sl   = SEL_JMP;
                        redirect = 1'b1;
                    end
                    EV_HALT: begin
                        state_nxt     = ST_HALT;
                        fetch_valid_d = 1'b0;
                    end
                    EV_STALL: begin
                        // PC and fetch_valid simply hold.
                    end
                    default: begin
                        pc_d = pc_next;
                    end
                endcase
            end

            ST_FLUSH: begin
                // Only a redirect matters here; a halt or stall seen now
                // belongs to the wrong path and is dropped.
                if (ev == EV_BRANCH) begin
                    dir_sl   = SEL_BR;
                    redirect = 1'b1;
                end else if (ev == EV_JUMP) begin
                    dir_sl   = SEL_JMP;
                    redirect = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_done) begin
                        state_nxt     = ST_RUN;
                        fetch_valid_d = 1'b1;
                    end
                end
            end

            default: begin
                // ST_HALT: everything but rst is ignored.
            end
        endcase

        // Any accepted redirect loads the target and (re)starts the bubble.
        if (redirect) begin
            pc_d          = pc_next;
            state_nxt     = ST_FLUSH;
            fetch_valid_d = 1'b0;
            cnt_load      = 1'b1;
        end
    end

    // IF/ID is killed in the redirect cycle itself and for every bubble cycle.
    assign flush  = redirect || (state == ST_FLUSH);
    assign halted = (state == ST_HALT);

    // State, PC and fetch_valid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_d;
            fetch_valid <= fetch_valid_d;
        end
    end

    flush_counter #(
        .W (FLUSH_CNT_W)
    ) u_flush_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (FLUSH_LOAD),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl. Two instances share stimulus:
// one with a 1-cycle bubble, one with a 3-cycle bubble. Each row of a
// plan drives the inputs for one cycle and pushes the outputs expected
// in that cycle; they are popped and compared shortly after the drive.
module tb_fetch_pc_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic       jump_req = 1'b0;
    logic       halt_req = 1'b0;
    logic [9:0] br_t = '0;
    logic [9:0] jmp_t = '0;

    logic [9:0] pc_next1, pc1, pc_seq1;
    logic [2:0] dir1;
    logic       fv1, fl1, h1;
    logic [9:0] pc_next3, pc3, pc_seq3;
    logic [2:0] dir3;
    logic       fv3, fl3, h3;

    // Behavioural stand-in for the fetch PC mux beside each controller.
    assign pc_next1 = (dir1 == 3'd1) ? br_t : (dir1 == 3'd2) ? jmp_t : pc_seq1;
    assign pc_next3 = (dir3 == 3'd1) ? br_t : (dir3 == 3'd2) ? jmp_t : pc_seq3;

    fetch_pc_ctrl #(.PC_W(10), .RESET_PC(10'h000), .FLUSH_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .jump_req(jump_req), .halt_req(halt_req), .pc_next(pc_next1),
        .pc(pc1), .pc_seq(pc_seq1), .dir_sl(dir1), .fetch_valid(fv1),
        .flush(fl1), .halted(h1)
    );

    fetch_pc_ctrl #(.PC_W(10), .RESET_PC(10'h000), .FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .jump_req(jump_req), .halt_req(halt_req), .pc_next(pc_next3),
        .pc(pc3), .pc_seq(pc_seq3), .dir_sl(dir3), .fetch_valid(fv3),
        .flush(fl3), .halted(h3)
    );

    typedef struct packed {
        logic [9:0] pc;
        logic       fv;
        logic       fl;
        logic [2:0] dir;
        logic       hl;
    } obs_t;

    typedef struct packed {
        logic       r;
        logic       st;
        logic       br;
        logic       jm;
        logic       hq;
        logic [9:0] bt;
        logic [9:0] jt;
        obs_t       exp;
    } row_t;

    obs_t obs1, obs3;
    assign obs1 = {pc1, fv1, fl1, dir1, h1};
    assign obs3 = {pc3, fv3, fl3, dir3, h3};

    int   vectors = 0;
    int   miscompares = 0;
    obs_t sb[$];
    row_t plan[$];

    function automatic row_t mk(input logic r, input logic st, input logic br,
                                input logic jm, input logic hq,
                                input logic [9:0] bt, input logic [9:0] jt,
                                input logic [9:0] epc, input logic efv,
                                input logic efl, input logic [2:0] edir,
                                input logic ehl);
        row_t x;
        x.r = r; x.st = st; x.br = br; x.jm = jm; x.hq = hq;
        x.bt = bt; x.jt = jt;
        x.exp = {epc, efv, efl, edir, ehl};
        return x;
    endfunction

    // Quiet cycle in RUN/BOOT/HALT-free context.
    function automatic row_t idle(input logic [9:0] epc, input logic efv);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, epc, efv, 1'b0, 3'd0, 1'b0);
    endfunction

    // Quiet cycle while a bubble is being counted out.
    function automatic row_t flushing(input logic [9:0] epc);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, epc, 1'b0, 1'b1, 3'd0, 1'b0);
    endfunction

    task automatic drive_row(input row_t x);
        rst          = x.r;
        stall        = x.st;
        branch_taken = x.br;
        jump_req     = x.jm;
        halt_req     = x.hq;
        br_t         = x.bt;
        jmp_t        = x.jt;
        sb.push_back(x.exp);
    endtask

    // One reset edge, then an empty plan; the next row lands in BOOT.
    task automatic reset_dut();
        @(negedge clk);
        drive_row(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 10'h0, 1'b0, 1'b0, 3'd0, 1'b0));
        void'(sb.pop_back());
        plan.delete();
    endtask

    // BOOT cycle, then free-running RUN cycles with pc = 0 .. n-1.
    task automatic plan_boot(input int n);
        plan.push_back(idle(10'h000, 1'b0));
        for (int k = 0; k < n; k++) plan.push_back(idle(10'(k), 1'b1));
    endtask

    task automatic test_reset();
        obs_t got, want;
        reset_dut();
        plan_boot(4);
        foreach (plan[i]) begin
            @(negedge clk); drive_row(plan[i]); #1;
            got = obs1; want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset[%0d]: got pc=%h fv=%b fl=%b dir=%0d hl=%b, want pc=%h fv=%b fl=%b dir=%0d hl=%b",
                         i, got.pc, got.fv, got.fl, got.dir, got.hl, want.pc, want.fv, want.fl, want.dir, want.hl);
            end
        end
    endtask

    task automatic test_branch();
        obs_t got, want;
        reset_dut();
        plan_boot(5);
        plan.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h2A0, 10'h0, 10'h005, 1'b1, 1'b1, 3'd1, 1'b0));
        plan.push_back(flushing(10'h2A0));
        plan.push_back(idle(10'h2A0, 1'b1));
        plan.push_back(idle(10'h2A1, 1'b1));
        foreach (plan[i]) begin
            @(negedge clk); drive_row(plan[i]); #1;
            got = obs1; want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL branch[%0d]: got pc=%h fv=%b fl=%b dir=%0d hl=%b, want pc=%h fv=%b fl=%b dir=%0d hl=%b",
                         i, got.pc, got.fv, got.fl, got.dir, got.hl, want.pc, want.fv, want.fl, want.dir, want.hl);
            end
        end
    endtask

    // Branch beats jump; redirect in FLUSH; halt/stall ignored in FLUSH;
    // jump beats a concurrent stall in RUN.
    task automatic test_priority();
        obs_t got, want;
        reset_dut();
        plan_boot(2);
        plan.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h010, 10'h300, 10'h002, 1'b1, 1'b1, 3'd1, 1'b0));
        plan.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h300, 10'h010, 1'b0, 1'b1, 3'd2, 1'b0));
        plan.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 10'h000, 10'h300, 1'b0, 1'b1, 3'd0, 1'b0));
        plan.push_back(idle(10'h300, 1'b1));
        plan.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 10'h0F0, 10'h301, 1'b1, 1'b1, 3'd2, 1'b0));
        plan.push_back(flushing(10'h0F0));
        plan.push_back(idle(10'h0F0, 1'b1));
        plan.push_back(idle(10'h0F1, 1'b1));
        foreach (plan[i]) begin
            @(negedge clk); drive_row(plan[i]); #1;
            got = obs1; want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL priority[%0d]: got pc=%h fv=%b fl=%b dir=%0d hl=%b, want pc=%h fv=%b fl=%b dir=%0d hl=%b",
                         i, got.pc, got.fv, got.fl, got.dir, got.hl, want.pc, want.fv, want.fl, want.dir, want.hl);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t got, want;
        reset_dut();
        plan_boot(0);
        plan.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h3FF, 10'h000, 1'b1, 1'b1, 3'd2, 1'b0));
        plan.push_back(flushing(10'h3FF));
        plan.push_back(idle(10'h3FF, 1'b1));
        plan.push_back(idle(10'h000, 1'b1));
        plan.push_back(idle(10'h001, 1'b1));
        foreach (plan[i]) begin
            @(negedge clk); drive_row(plan[i]); #1;
            got = obs1; want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got pc=%h fv=%b fl=%b dir=%0d hl=%b, want pc=%h fv=%b fl=%b dir=%0d hl=%b",
                         i, got.pc, got.fv, got.fl, got.dir, got.hl, want.pc, want.fv, want.fl, want.dir, want.hl);
            end
        end
    endtask

    task automatic test_stall();
        obs_t got, want;
        reset_dut();
        plan_boot(7);
        for (int k = 0; k < 3; k++)
            plan.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 10'h007, 1'b1, 1'b0, 3'd0, 1'b0));
        plan.push_back(idle(10'h007, 1'b1));
        plan.push_back(idle(10'h008, 1'b1));
        foreach (plan[i]) begin
            @(negedge clk); drive_row(plan[i]); #1;
            got = obs1; want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL stall[%0d]: got pc=%h fv=%b fl=%b dir=%0d hl=%b, want pc=%h fv=%b fl=%b dir=%0d hl=%b",
                         i, got.pc, got.fv, got.fl, got.dir, got.hl, want.pc, want.fv, want.fl, want.dir, want.hl);
            end
        end
    endtask

    task automatic test_halt();
        obs_t got, want;
        reset_dut();
        plan_boot(9);
        plan.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h0, 10'h0, 10'h009, 1'b1, 1'b0, 3'd0, 1'b0));
        for (int k = 0; k < 10; k++)
            plan.push_back(mk(1'b0, 1'(k % 2), 1'b1, 1'(k % 3 == 0), 1'b1, 10'h123, 10'h1EE,
                              10'h009, 1'b0, 1'b0, 3'd0, 1'b1));
        plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 10'h009, 1'b0, 1'b0, 3'd0, 1'b1));
        plan.push_back(idle(10'h000, 1'b0));
        plan.push_back(idle(10'h000, 1'b1));
        foreach (plan[i]) begin
            @(negedge clk); drive_row(plan[i]); #1;
            got = obs1; want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL halt[%0d]: got pc=%h fv=%b fl=%b dir=%0d hl=%b, want pc=%h fv=%b fl=%b dir=%0d hl=%b",
                         i, got.pc, got.fv, got.fl, got.dir, got.hl, want.pc, want.fv, want.fl, want.dir, want.hl);
            end
        end
    endtask

    // Three-cycle bubble instance: bubble length, counter reload on a
    // redirect inside FLUSH, and reset landing mid-FLUSH.
    task automatic test_flush3();
        obs_t got, want;
        reset_dut();
        plan_boot(2);
        plan.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0AA, 10'h0, 10'h002, 1'b1, 1'b1, 3'd1, 1'b0));
        for (int k = 0; k < 3; k++) plan.push_back(flushing(10'h0AA));
        plan.push_back(idle(10'h0AA, 1'b1));
        plan.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h200, 10'h0, 10'h0AB, 1'b1, 1'b1, 3'd1, 1'b0));
        plan.push_back(flushing(10'h200));
        plan.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, 10'h280, 10'h200, 1'b0, 1'b1, 3'd2, 1'b0));
        for (int k = 0; k < 3; k++) plan.push_back(flushing(10'h280));
        plan.push_back(idle(10'h280, 1'b1));
        plan.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h3C0, 10'h0, 10'h281, 1'b1, 1'b1, 3'd1, 1'b0));
        plan.push_back(flushing(10'h3C0));
        plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 10'h3C0, 1'b0, 1'b1, 3'd0, 1'b0));
        plan.push_back(idle(10'h000, 1'b0));
        plan.push_back(idle(10'h000, 1'b1));
        foreach (plan[i]) begin
            @(negedge clk); drive_row(plan[i]); #1;
            got = obs3; want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL flush3[%0d]: got pc=%h fv=%b fl=%b dir=%0d hl=%b, want pc=%h fv=%b fl=%b dir=%0d hl=%b",
                         i, got.pc, got.fv, got.fl, got.dir, got.hl, want.pc, want.fv, want.fl, want.dir, want.hl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_priority();
        test_wrap();
        test_stall();
        test_halt();
        test_flush3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
